// File: rtl/forward_scoreboard_pkg.sv
// Shared types and helpers for the forwarding scoreboard: pipeline entry layout,
// the hard-wired zero register and the forward-select width function.
package forward_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regWrite;
    logic       memRead;
  } entry_t;

  function automatic int selWidth(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/forward_scoreboard_if.sv
// ID-stage query / forward-select bundle between the pipeline (master) and the scoreboard (slave).
// FWD_BRANCH_ID_EN adds id_branch and id_fwd for branch compares resolved in ID.
interface forward_scoreboard_if #(
  parameter int NUM_PORTS = 2,
  parameter int SEL_W     = 2
);
  logic                       ext_stall;
  logic                       flush;
  logic                       id_valid;
  logic [4:0]                 id_rd;
  logic                       id_regwrite;
  logic                       id_memread;
  logic [5*NUM_PORTS-1:0]     q_addr;
  logic [NUM_PORTS-1:0]       q_used;
  logic [SEL_W*NUM_PORTS-1:0] fwd_sel;
  logic                       hazard_stall;
  logic [15:0]                stall_count;
`ifdef FWD_BRANCH_ID_EN
  logic                       id_branch;
  logic [NUM_PORTS-1:0]       id_fwd;

  modport master (
    output ext_stall, flush, id_valid, id_rd, id_regwrite, id_memread, q_addr, q_used, id_branch,
    input  fwd_sel, hazard_stall, stall_count, id_fwd
  );
  modport slave (
    input  ext_stall, flush, id_valid, id_rd, id_regwrite, id_memread, q_addr, q_used, id_branch,
    output fwd_sel, hazard_stall, stall_count, id_fwd
  );
`else
  modport master (
    output ext_stall, flush, id_valid, id_rd, id_regwrite, id_memread, q_addr, q_used,
    input  fwd_sel, hazard_stall, stall_count
  );
  modport slave (
    input  ext_stall, flush, id_valid, id_rd, id_regwrite, id_memread, q_addr, q_used,
    output fwd_sel, hazard_stall, stall_count
  );
`endif
endinterface

// File: rtl/forward_scoreboard_match.sv
// Youngest-match priority encoder for one ID source port against the in-flight entries.
module forward_match
  import forward_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = selWidth(DEPTH)
) (
  input  entry_t [DEPTH-1:0] entries,
  input  logic [4:0]         qAddr,
  input  logic               qUsed,
  output logic               hit,
  output logic [SEL_W-1:0]   hitIdx,
  output logic               hitMemRead
);

  logic [DEPTH-1:0] hitVec_s;

  // Per-entry producer match; register 0 is never a producer
  always_comb begin
    hitVec_s = {DEPTH{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      hitVec_s[k] = entries[k].valid & entries[k].regWrite & (entries[k].rd != REG_ZERO)
                  & (entries[k].rd == qAddr) & qUsed;
    end
  end

  // Scan oldest to youngest so the youngest hit overwrites older ones
  always_comb begin
    hitIdx     = {SEL_W{1'b0}};
    hitMemRead = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      hitIdx     = hitVec_s[k] ? SEL_W'(k) : hitIdx;
      hitMemRead = hitVec_s[k] ? entries[k].memRead : hitMemRead;
    end
  end

  assign hit = |hitVec_s;

endmodule

// File: rtl/forward_scoreboard.sv
// Operand-forwarding scoreboard: tracks in-flight destinations, registers EX operand selects
// and requests load-use stalls. Optional FWD_BRANCH_ID_EN adds ID-stage branch forwarding.
module forward_scoreboard
  import forward_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int DEPTH     = 3,
  parameter int SEL_W     = selWidth(DEPTH)
) (
  input logic                 clk,
  input logic                 rst,
  forward_scoreboard_if.slave sb
);

  localparam logic [SEL_W-1:0] ZERO_SEL = {SEL_W{1'b0}};
  localparam logic [SEL_W-1:0] ONE_SEL  = SEL_W'(1'b1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(DEPTH - 1);

  entry_t [DEPTH-1:0]         entries_r;
  logic [SEL_W*NUM_PORTS-1:0] fwdSel_r;
  logic [15:0]                stallCount_r;

  logic [NUM_PORTS-1:0]       hit_s;
  logic [NUM_PORTS-1:0]       hitMemRead_s;
  logic [SEL_W-1:0]           hitIdx_s [NUM_PORTS];
  logic [SEL_W*NUM_PORTS-1:0] fwdSelNext_s;
  logic                       loadUse_s;
  logic                       branchHaz_s;
  logic                       hazard_s;
  logic                       loadEntry_s;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    forward_match #(
      .DEPTH (DEPTH),
      .SEL_W (SEL_W)
    ) u_match (
      .entries    (entries_r),
      .qAddr      (sb.q_addr[p*5 +: 5]),
      .qUsed      (sb.q_used[p]),
      .hit        (hit_s[p]),
      .hitIdx     (hitIdx_s[p]),
      .hitMemRead (hitMemRead_s[p])
    );
  end

  // Load-use: the youngest producer is still a load sitting in EX
  always_comb begin
    loadUse_s = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      loadUse_s = loadUse_s | (hit_s[p] & (hitIdx_s[p] == ZERO_SEL) & hitMemRead_s[p]);
    end
  end

`ifdef FWD_BRANCH_ID_EN
  logic [NUM_PORTS-1:0] idFwd_s;

  // Branch in ID needs its operands one stage earlier than an ALU op
  always_comb begin
    branchHaz_s = 1'b0;
    idFwd_s     = {NUM_PORTS{1'b0}};
    for (int p = 0; p < NUM_PORTS; p++) begin
      branchHaz_s = branchHaz_s | (sb.id_branch & hit_s[p]
                    & ((hitIdx_s[p] == ZERO_SEL) | ((hitIdx_s[p] == ONE_SEL) & hitMemRead_s[p])));
      idFwd_s[p]  = hit_s[p] & (hitIdx_s[p] == ONE_SEL) & ~hitMemRead_s[p];
    end
  end

  assign sb.id_fwd = idFwd_s;
`else
  assign branchHaz_s = 1'b0;
`endif

  assign hazard_s    = sb.id_valid & ~sb.flush & (loadUse_s | branchHaz_s);
  assign loadEntry_s = sb.id_valid & ~sb.flush & ~hazard_s;

  // Next select: entry k becomes stage k+1 after the shift; a retiring producer reads the RF
  always_comb begin
    fwdSelNext_s = {(SEL_W*NUM_PORTS){1'b0}};
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (loadEntry_s && hit_s[p] && (hitIdx_s[p] != LAST_IDX)) begin
        fwdSelNext_s[p*SEL_W +: SEL_W] = hitIdx_s[p] + ONE_SEL;
      end else begin
        fwdSelNext_s[p*SEL_W +: SEL_W] = ZERO_SEL;
      end
    end
  end

  // Pipeline shift, select and stall-counter registers; freeze holds everything
  always_ff @(posedge clk) begin
    if (rst) begin
      entries_r    <= {DEPTH{entry_t'(7'd0)}};
      fwdSel_r     <= {(SEL_W*NUM_PORTS){1'b0}};
      stallCount_r <= 16'd0;
    end else if (!sb.ext_stall) begin
      for (int k = 1; k < DEPTH; k++) begin
        entries_r[k] <= entries_r[k-1];
      end
      if (loadEntry_s) begin
        entries_r[0] <= '{valid: 1'b1, rd: sb.id_rd, regWrite: sb.id_regwrite, memRead: sb.id_memread};
      end else begin
        entries_r[0] <= entry_t'(7'd0);
      end
      fwdSel_r <= fwdSelNext_s;
      if (hazard_s && (stallCount_r != 16'hFFFF)) begin
        stallCount_r <= stallCount_r + 16'd1;
      end
    end
  end

  assign sb.fwd_sel      = fwdSel_r;
  assign sb.stall_count  = stallCount_r;
  assign sb.hazard_stall = hazard_s;

endmodule

// File: doc/forward_scoreboard.md
FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of ID-stage source-register query ports.
REQ-002 SHALL have parameter DEPTH, default 3, number of tracked in-flight stages (entry 0 = EX, 1 = MEM, 2 = WB, ...); legal range 2..8.
REQ-003 SHALL have parameter SEL_W, default 2, forward-select width, equal to ceil(log2(DEPTH)).
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port ext_stall, input, 1, global pipeline freeze.
REQ-007 SHALL have port flush, input, 1, kill the instruction in ID.
REQ-008 SHALL have port id_valid, input, 1, ID holds a real instruction.
REQ-009 SHALL have port id_rd, input, 5, ID destination register.
REQ-010 SHALL have port id_regwrite, input, 1, ID instruction writes id_rd.
REQ-011 SHALL have port id_memread, input, 1, ID instruction is a load.
REQ-012 SHALL have port q_addr, input, 5*NUM_PORTS, ID source register per port.
REQ-013 SHALL have port q_used, input, NUM_PORTS, port p is actually read.
REQ-014 SHALL have port fwd_sel, output, SEL_W*NUM_PORTS, registered EX-stage operand select per port (0 = register file, k = stage k pipeline register).
REQ-015 SHALL have port hazard_stall, output, 1, combinational load-use stall request.
REQ-016 SHALL have port stall_count, output, 16, saturating count of hazard_stall cycles.

Function
REQ-017 SHALL hold a DEPTH-entry shift pipeline of {valid, rd, regwrite, memread}.
REQ-018 SHALL treat entry k as a match for port p iff valid, regwrite, rd != 0, rd == q_addr[p], and q_used[p].
REQ-019 SHALL select per port the youngest (lowest k) match; older matches are ignored.
REQ-020 SHALL assert hazard_stall when any port's youngest match is entry 0 with memread = 1 and id_valid = 1 and flush = 0.
REQ-021 SHALL, on each clock with ext_stall = 0, shift entry k into k+1, discard entry DEPTH-1, and load entry 0 from ID (id_valid & ~flush & ~hazard_stall), otherwise a bubble.
REQ-022 SHALL, on the same edge, register fwd_sel[p] = k+1 for a youngest match at k < DEPTH-1, and 0 for a match at DEPTH-1 (retiring, write-before-read register file) or for no match.
REQ-023 SHALL register fwd_sel = 0 for all ports when a bubble enters entry 0.
REQ-024 SHALL, with ext_stall = 1, hold entries, fwd_sel and stall_count unchanged; ext_stall has priority over flush and hazard_stall.
REQ-025 SHALL give flush priority over hazard_stall: flush = 1 forces hazard_stall = 0 and inserts a bubble.
REQ-026 SHALL increment stall_count on each non-frozen cycle with hazard_stall = 1, saturating at 16'hFFFF.
REQ-027 SHALL never stall or forward for register 0.

Reset
REQ-028 SHALL, on rst = 1 at clk, clear all entry valid bits, fwd_sel to 0, stall_count to 0; rst overrides ext_stall.
REQ-029 SHALL drive hazard_stall = 0 while all entries are invalid (true during and after reset).

Configuration
REQ-030 SHALL with macro FWD_BRANCH_ID_EN defined add output id_fwd (NUM_PORTS, combinational): 1 when the port's youngest match is entry 1 with memread = 0, for branch compare in ID.
REQ-031 SHALL with FWD_BRANCH_ID_EN defined add input id_branch; when 1 and the youngest match is entry 0 (any) or entry 1 with memread = 1, hazard_stall SHALL assert.
REQ-032 SHALL without FWD_BRANCH_ID_EN have neither port; behaviour is REQ-017..027 only.

Structure
REQ-033 SHALL place the entry struct typedef, register-0 constant and select-width function in shared package forward_pkg.
REQ-034 SHALL implement the per-port youngest-match priority encoder as sub-module forward_match, instantiated NUM_PORTS times.

Verification
REQ-035 SHALL test ALU-ALU: add $3 then sub using $3 -> next cycle fwd_sel[0] = 1, no stall.
REQ-036 SHALL test distance 2: add $3, nop, use $3 on port 1 -> fwd_sel[1] = 2; distance 3 -> 0.
REQ-037 SHALL test load-use: lw $4, then use $4 -> hazard_stall = 1 one cycle, bubble, then fwd_sel = 2, stall_count = 1.
REQ-038 SHALL test youngest-wins: add $5, add $5, use $5 -> fwd_sel = 1; write to $0 never forwards or stalls.
REQ-039 SHALL test ext_stall held 3 cycles mid-load-use -> entries, fwd_sel, stall_count frozen; flush with load-use -> no stall, bubble.
REQ-040 SHALL test with FWD_BRANCH_ID_EN: add $6 then beq on $6 -> one stall, then id_fwd[0] = 1.
